// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, shared FSM state type and scroll helper.
// The optional background scroll is enabled with macro VGA_SCROLL_EN.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int BG_WIDTH = 320;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } tstate_e;

    // Step is at most 15, so one conditional subtract keeps the result in range.
    function automatic logic [8:0] scroll_add(input logic [8:0] x,
                                              input logic [3:0] step);
        logic [9:0] sum;
        sum = {1'b0, x} + {6'd0, step};
        if (sum >= 10'(BG_WIDTH)) begin
            sum = sum - 10'(BG_WIDTH);
        end
        return sum[8:0];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, registered syncs and blank.
// Define VGA_SCROLL_EN to enable the per-frame background scroll accumulator.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  scroll_step,
    output logic [10:0] hcounter,
    output logic [10:0] vcounter,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [8:0]  scroll_x
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    tstate_e     state_q, state_d;
    logic [3:0]  div_q, div_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_q, blank_d;
    logic        pix_tick_q, pix_tick_d;
    logic        frame_start_q, frame_start_d;

    always_comb begin
        div_d         = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        pix_tick_d    = (div_d == DIV_LAST);
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_start_d = 1'b0;

        if (pix_tick_q) begin
            unique case (state_q)
                // Leaving hold keeps (0,0) for one more pixel: that pixel is the first of the frame.
                ST_HOLD: begin
                    if (run) begin
                        state_d       = ST_RUN;
                        frame_start_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_d = 11'd0;
                        if (vcnt_q == V_LAST) begin
                            vcnt_d = 11'd0;
                            if (run) begin
                                frame_start_d = 1'b1;
                            end else begin
                                state_d = ST_HOLD;
                            end
                        end else begin
                            vcnt_d = vcnt_q + 11'd1;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 11'd1;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end

        // Decoded from the next counter values so the flops line up with the counters.
        hsync_d = !((hcnt_d >= HS_BEG) && (hcnt_d < HS_END));
        vsync_d = !((vcnt_d >= VS_BEG) && (vcnt_d < VS_END));
        blank_d = (state_d == ST_HOLD) || (hcnt_d >= H_VIS) || (vcnt_d >= V_VIS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HOLD;
            div_q         <= 4'd0;
            hcnt_q        <= 11'd0;
            vcnt_q        <= 11'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b1;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcounter    = hcnt_q;
    assign vcounter    = vcnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign pix_tick    = pix_tick_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SCROLL_EN
    logic [8:0] scroll_q, scroll_d;

    always_comb begin
        scroll_d = frame_start_q ? scroll_add(scroll_q, scroll_step) : scroll_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scroll_q <= 9'd0;
        end else begin
            scroll_q <= scroll_d;
        end
    end

    assign scroll_x = scroll_q;
`else
    logic scroll_unused;
    assign scroll_unused = ^scroll_step;
    assign scroll_x      = 9'd0;
`endif

endmodule
